approx_product_accumulator: RTL and testbench

APPROX_PRODUCT_ACCUMULATOR -- requirements
Module: approx_product_accumulator

---
 rtl/approx_product_accumulator_if.sv | 26 ++
 rtl/approx_product_accumulator.sv | 124 ++++++++++++
 tb/tb_approx_product_accumulator.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/approx_product_accumulator_if.sv
// Beat/result handshake bundle for approx_product_accumulator.
// master = upstream/downstream environment, slave = the accumulator itself.
interface approx_product_accumulator_if #(
   parameter int ACC_W = 24,
   parameter int CNT_W = 8
);
   logic [15:0]      z;
   logic             in_valid;
   logic             in_last;
   logic             in_ready;
   logic [ACC_W-1:0] acc_out;
   logic [CNT_W-1:0] cnt_out;
   logic             sat_out;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output z, in_valid, in_last, out_ready,
      input  in_ready, acc_out, cnt_out, sat_out, out_valid
   );

   modport slave (
      input  z, in_valid, in_last, out_ready,
      output in_ready, acc_out, cnt_out, sat_out, out_valid
   );
endinterface

// File: rtl/approx_product_accumulator.sv
// Saturating per-packet accumulator for 16-bit approximate-multiplier products.
// Two states: ACCUM takes one beat per cycle, DRAIN holds the result until consumed.
module approx_product_accumulator #(
   parameter int ACC_W = 24,
   parameter int CNT_W = 8
) (
   input logic                          clk,
   input logic                          rst,
   approx_product_accumulator_if.slave  bus
);

   generate
      if (ACC_W < 16 || ACC_W > 32) begin : g_bad_acc_w
         $error("approx_product_accumulator: ACC_W must be in 16..32");
      end
      if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
         $error("approx_product_accumulator: CNT_W must be in 2..16");
      end
   endgenerate

   localparam logic [0:0] ST_ACCUM = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   logic [0:0]       state_q;

   // Running (in-flight) packet state
   logic [ACC_W-1:0] acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             sat_q;

   // Completed-packet result registers
   logic [ACC_W-1:0] res_acc_q;
   logic [CNT_W-1:0] res_cnt_q;
   logic             res_sat_q;

   logic             beat_fire;
   logic             drain_fire;
   logic [ACC_W:0]   sum_ext;
   logic             acc_clamp;
   logic             cnt_clamp;
   logic [ACC_W-1:0] acc_next;
   logic [CNT_W-1:0] cnt_next;
   logic             sat_next;

   // Handshake is decoded from state only, so in_valid/out_ready never reach in_ready/out_valid.
   assign bus.in_ready  = (state_q == ST_ACCUM);
   assign bus.out_valid = (state_q == ST_DRAIN);
   assign bus.acc_out   = res_acc_q;
   assign bus.cnt_out   = res_cnt_q;
   assign bus.sat_out   = res_sat_q;

   assign beat_fire  = bus.in_valid  && (state_q == ST_ACCUM);
   assign drain_fire = bus.out_ready && (state_q == ST_DRAIN);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      sum_ext   = '0;
      acc_clamp = 1'b0;
      acc_next  = '0;
      cnt_clamp = 1'b0;
      cnt_next  = '0;
      sat_next  = 1'b0;

      // One extra bit of headroom catches the carry that signals a clamp.
      sum_ext   = {1'b0, acc_q} + (ACC_W+1)'(bus.z);
      acc_clamp = sum_ext[ACC_W];
      acc_next  = acc_clamp ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];

      cnt_clamp = &cnt_q;
      cnt_next  = cnt_clamp ? cnt_q : cnt_q + CNT_W'(1);

      sat_next  = sat_q | acc_clamp | cnt_clamp;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_ACCUM;
         acc_q     <= '0;
         cnt_q     <= '0;
         sat_q     <= 1'b0;
         res_acc_q <= '0;
         res_cnt_q <= '0;
         res_sat_q <= 1'b0;
      end else begin
         case (state_q)
            ST_ACCUM: begin
               if (beat_fire) begin
                  if (bus.in_last) begin
                     res_acc_q <= acc_next;
                     res_cnt_q <= cnt_next;
                     res_sat_q <= sat_next;
                     acc_q     <= '0;
                     cnt_q     <= '0;
                     sat_q     <= 1'b0;
                     state_q   <= ST_DRAIN;
                  end else begin
                     acc_q     <= acc_next;
                     cnt_q     <= cnt_next;
                     sat_q     <= sat_next;
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_fire) begin
                  state_q <= ST_ACCUM;
               end
            end
            default: state_q <= ST_ACCUM;
         endcase
      end
   end

   // Results must not move while downstream is stalling us.
   a_drain_stable: assert property (@(posedge clk) disable iff (rst)
      (state_q == ST_DRAIN && !bus.out_ready) |=>
         ($stable(res_acc_q) && $stable(res_cnt_q) && $stable(res_sat_q)
          && state_q == ST_DRAIN));

   // Running state is always empty while a result waits in DRAIN.
   a_drain_idle: assert property (@(posedge clk) disable iff (rst)
      (state_q == ST_DRAIN) |-> (acc_q == '0 && cnt_q == '0 && !sat_q));

endmodule

// File: tb/tb_approx_product_accumulator.sv
// Directed bench: one default-width instance (A) and one narrow instance (B: ACC_W=16, CNT_W=2)
// driven by the same stimulus, checked against hand-computed tables.
module tb_approx_product_accumulator;

   logic        clk;
   logic        rst;
   logic [15:0] z;
   logic        in_valid;
   logic        in_last;
   logic        out_ready;

   int total;
   int bad;

   approx_product_accumulator_if #(.ACC_W(24), .CNT_W(8)) if_a ();
   approx_product_accumulator_if #(.ACC_W(16), .CNT_W(2)) if_b ();

   assign if_a.z         = z;
   assign if_a.in_valid  = in_valid;
   assign if_a.in_last   = in_last;
   assign if_a.out_ready = out_ready;
   assign if_b.z         = z;
   assign if_b.in_valid  = in_valid;
   assign if_b.in_last   = in_last;
   assign if_b.out_ready = out_ready;

   approx_product_accumulator #(.ACC_W(24), .CNT_W(8)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (if_a)
   );

   approx_product_accumulator #(.ACC_W(16), .CNT_W(2)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (if_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] z;
      logic        v;
      logic        l;
      logic        ordy;
      logic        ir;
      logic        ov;
      logic [31:0] acc_a;
      logic [7:0]  cnt_a;
      logic        sat_a;
      logic [31:0] acc_b;
      logic [7:0]  cnt_b;
      logic        sat_b;
   } vec_t;

   localparam int N_VEC = 20;
   vec_t tbl [N_VEC];

   function automatic vec_t mk(input logic [15:0] zz, input logic v, input logic l,
                               input logic ordy, input logic ir, input logic ov,
                               input logic [31:0] acc_a, input logic [7:0] cnt_a,
                               input logic sat_a, input logic [31:0] acc_b,
                               input logic [7:0] cnt_b, input logic sat_b);
      vec_t r;
      r.z = zz; r.v = v; r.l = l; r.ordy = ordy; r.ir = ir; r.ov = ov;
      r.acc_a = acc_a; r.cnt_a = cnt_a; r.sat_a = sat_a;
      r.acc_b = acc_b; r.cnt_b = cnt_b; r.sat_b = sat_b;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic ir, input logic ov,
                            input logic [31:0] acc_a, input logic [7:0] cnt_a, input logic sat_a,
                            input logic [31:0] acc_b, input logic [7:0] cnt_b, input logic sat_b);
      check({tag, " a.in_ready"},  32'(if_a.in_ready),  32'(ir));
      check({tag, " a.out_valid"}, 32'(if_a.out_valid), 32'(ov));
      check({tag, " a.acc_out"},   32'(if_a.acc_out),   acc_a);
      check({tag, " a.cnt_out"},   32'(if_a.cnt_out),   32'(cnt_a));
      check({tag, " a.sat_out"},   32'(if_a.sat_out),   32'(sat_a));
      check({tag, " b.in_ready"},  32'(if_b.in_ready),  32'(ir));
      check({tag, " b.out_valid"}, 32'(if_b.out_valid), 32'(ov));
      check({tag, " b.acc_out"},   32'(if_b.acc_out),   acc_b);
      check({tag, " b.cnt_out"},   32'(if_b.cnt_out),   32'(cnt_b));
      check({tag, " b.sat_out"},   32'(if_b.sat_out),   32'(sat_b));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] zz, input logic v, input logic l, input logic ordy);
      z         = zz;
      in_valid  = v;
      in_last   = l;
      out_ready = ordy;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      drive(16'h0, 1'b0, 1'b0, 1'b0);

      //             z        v  l  ordy ir ov acc_a        cnt a sa acc_b      cnt b sb
      // single beat 0xF910
      tbl[0]  = mk(16'hF910, 1, 1, 0,   0, 1, 32'h00F910, 1, 0, 32'hF910, 1, 0);
      tbl[1]  = mk(16'h0000, 0, 0, 1,   1, 0, 32'h00F910, 1, 0, 32'hF910, 1, 0);
      // burst 1,2,3,4; B's 2-bit counter clamps at 3
      tbl[2]  = mk(16'h0001, 1, 0, 1,   1, 0, 32'h00F910, 1, 0, 32'hF910, 1, 0);
      tbl[3]  = mk(16'h0002, 1, 0, 1,   1, 0, 32'h00F910, 1, 0, 32'hF910, 1, 0);
      tbl[4]  = mk(16'h0003, 1, 0, 1,   1, 0, 32'h00F910, 1, 0, 32'hF910, 1, 0);
      tbl[5]  = mk(16'h0004, 1, 1, 1,   0, 1, 32'd10,     4, 0, 32'd10,   3, 1);
      tbl[6]  = mk(16'h0000, 0, 0, 1,   1, 0, 32'd10,     4, 0, 32'd10,   3, 1);
      // sum overflow: A holds 0x1F220, B clamps to 0xFFFF
      tbl[7]  = mk(16'hF910, 1, 0, 0,   1, 0, 32'd10,     4, 0, 32'd10,   3, 1);
      tbl[8]  = mk(16'hF910, 1, 1, 0,   0, 1, 32'h01F220, 2, 0, 32'hFFFF, 2, 1);
      // backpressure with in_valid held high: nothing moves
      tbl[9]  = mk(16'h1234, 1, 1, 0,   0, 1, 32'h01F220, 2, 0, 32'hFFFF, 2, 1);
      tbl[10] = mk(16'h1234, 1, 1, 0,   0, 1, 32'h01F220, 2, 0, 32'hFFFF, 2, 1);
      tbl[11] = mk(16'h1234, 1, 1, 0,   0, 1, 32'h01F220, 2, 0, 32'hFFFF, 2, 1);
      tbl[12] = mk(16'h1234, 1, 1, 0,   0, 1, 32'h01F220, 2, 0, 32'hFFFF, 2, 1);
      tbl[13] = mk(16'h1234, 1, 1, 0,   0, 1, 32'h01F220, 2, 0, 32'hFFFF, 2, 1);
      // release: in_valid still high on the drain edge, beat must not be taken
      tbl[14] = mk(16'h1234, 1, 1, 1,   1, 0, 32'h01F220, 2, 0, 32'hFFFF, 2, 1);
      // next packet single beat 5, sat cleared
      tbl[15] = mk(16'h0005, 1, 1, 0,   0, 1, 32'd5,      1, 0, 32'd5,    1, 0);
      tbl[16] = mk(16'h0000, 0, 0, 1,   1, 0, 32'd5,      1, 0, 32'd5,    1, 0);
      // exact full-scale on B without overflow: no sat
      tbl[17] = mk(16'hFFFE, 1, 0, 0,   1, 0, 32'd5,      1, 0, 32'd5,    1, 0);
      tbl[18] = mk(16'h0001, 1, 1, 0,   0, 1, 32'h00FFFF, 2, 0, 32'hFFFF, 2, 0);
      tbl[19] = mk(16'h0000, 0, 0, 1,   1, 0, 32'h00FFFF, 2, 0, 32'hFFFF, 2, 0);

      // Asynchronous reset between edges: outputs must clear without a clock edge
      #2 rst = 1'b1;
      #1 check_all("reset", 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      rst = 1'b0;
      check_all("post_reset", 1, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < N_VEC; i++) begin
         drive(tbl[i].z, tbl[i].v, tbl[i].l, tbl[i].ordy);
         tick();
         check_all($sformatf("row%0d", i), tbl[i].ir, tbl[i].ov,
                   tbl[i].acc_a, tbl[i].cnt_a, tbl[i].sat_a,
                   tbl[i].acc_b, tbl[i].cnt_b, tbl[i].sat_b);
      end

      // Mid-packet reset: two beats of 0x0100 are discarded
      drive(16'h0100, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      check_all("midpkt_pre", 1, 0, 32'h00FFFF, 2, 0, 32'hFFFF, 2, 0);
      drive(16'h0000, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1 check_all("midpkt_rst", 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      rst = 1'b0;
      drive(16'h0007, 1'b1, 1'b1, 1'b0);
      tick();
      check_all("midpkt_post", 0, 1, 32'd7, 1, 0, 32'd7, 1, 0);
      drive(16'h0000, 1'b0, 1'b0, 1'b1);
      tick();
      check_all("midpkt_drain", 1, 0, 32'd7, 1, 0, 32'd7, 1, 0);

      // Reset while a result is pending in DRAIN: result is dropped
      drive(16'h0009, 1'b1, 1'b1, 1'b0);
      tick();
      check_all("drain_pre", 0, 1, 32'd9, 1, 0, 32'd9, 1, 0);
      drive(16'h0000, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1 check_all("drain_rst", 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      rst = 1'b0;
      tick();
      check_all("drain_idle", 1, 0, 0, 0, 0, 0, 0, 0);
      drive(16'h0003, 1'b1, 1'b1, 1'b1);
      tick();
      check_all("drain_fresh", 0, 1, 32'd3, 1, 0, 32'd3, 1, 0);
      drive(16'h0000, 1'b0, 1'b0, 1'b1);
      tick();
      check_all("drain_done", 1, 0, 32'd3, 1, 0, 32'd3, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
